// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands, adds them one bit
// per cycle LSB first through a half-adder pair, and publishes sum/cout with a done pulse.

module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One-bit full adder: two half adders, carries merged with an OR.
  logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;

  halfAdder u_ha0 (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  halfAdder u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (fa_s),
    .c (ha1_c)
  );

  assign fa_c = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        // The edge that consumes the last bit also publishes the result.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 instance for directed, corner-case and random
// operations; WIDTH=4 instance for an exhaustive sweep of all operand pairs.

module tb_serial_add_ctrl;

  localparam int W  = 8;
  localparam int W4 = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start8, busy8, done8, cout8;
  logic [W-1:0]  a8, b8, sum8;
  logic [1:0]    st8;
  logic          start4, busy4, done4, cout4;
  logic [W4-1:0] a4, b4, sum4;
  logic [1:0]    st4;

  serial_add_ctrl #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_o(st8)
  );

  serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .state_o(st4)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [W:0] model8(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Driver: call at a negedge; returns at a negedge after the op has finished.
  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int idx;
    int busy_n;
    logic [W:0] e;
    a8 = a; b8 = b; start8 = 1'b1;
    exp_q.push_back(model8(a, b));
    @(negedge clk);
    start8 = 1'b0;
    a8 = W'($urandom);
    b8 = W'($urandom);
    check($sformatf("%s hold", tag), {cout8, sum8}, last_res);
    idx = -1;
    busy_n = 0;
    for (int t = 0; t < 3 * W; t++) begin
      if (done8) begin
        idx = t;
        break;
      end
      if (busy8) busy_n++;
      @(negedge clk);
    end
    check($sformatf("%s latency", tag), idx, W);
    check($sformatf("%s busy_cycles", tag), busy_n, W);
    e = exp_q.pop_front();
    if (idx >= 0) begin
      check($sformatf("%s result", tag), {cout8, sum8}, e);
      check($sformatf("%s busy_in_done", tag), busy8, 1'b0);
      last_res = e;
      @(negedge clk);
      check($sformatf("%s done_width", tag), done8, 1'b0);
    end
  endtask

  task automatic op4(input logic [W4-1:0] a, input logic [W4-1:0] b);
    int idx;
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    idx = -1;
    for (int t = 0; t < 3 * W4; t++) begin
      if (done4) begin
        idx = t;
        break;
      end
      @(negedge clk);
    end
    if (idx < 0) check($sformatf("exh %0h+%0h timeout", a, b), 0, 1);
    else check($sformatf("exh %0h+%0h", a, b), {cout4, sum4}, {1'b0, a} + {1'b0, b});
    @(negedge clk);
  endtask

  initial begin
    int n_done;
    int prev_t;
    int n_ops;
    logic [W:0] e;

    vecs[0] = '{a: 8'h00, b: 8'h00, es: 8'h00, ec: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, es: 8'h00, ec: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, es: 8'hFF, ec: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, es: 8'h00, ec: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h01, es: 8'h80, ec: 1'b0};
    vecs[5] = '{a: 8'h3C, b: 8'h0F, es: 8'h4B, ec: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, es: 8'hFE, ec: 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset sum_cout", {cout8, sum8}, '0);
    check("reset4 sum_cout", {busy4, done4, cout4, sum4}, '0);

    // First edge after reset release accepts start.
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op8(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), {cout8, sum8}, {vecs[i].ec, vecs[i].es});
    end

    // start pulsed during RUN and during DONE must be ignored.
    a8 = 8'h03; b8 = 8'h04; start8 = 1'b1;
    exp_q.push_back(model8(8'h03, 8'h04));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_done = 0;
    for (int t = 0; t < 3 * W; t++) begin
      start8 = 1'b0;
      if (done8) begin
        n_done++;
        if (n_done == 1) begin
          e = exp_q.pop_front();
          check("ignore result", {cout8, sum8}, e);
          check("ignore const", {cout8, sum8}, 9'h007);
          last_res = e;
          start8 = 1'b1;
        end
      end
      @(negedge clk);
    end
    check("ignore done_count", n_done, 1);

    // Reset mid-RUN after 4 bits aborts without a done pulse.
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy8, 1'b0);
    check("abort done", done8, 1'b0);
    check("abort sum_cout", {cout8, sum8}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int t = 0; t < 2 * W; t++) begin
      if (done8) n_done++;
      @(negedge clk);
    end
    check("abort no_done", n_done, 0);
    check("abort sum_after", {cout8, sum8}, '0);
    last_res = '0;
    op8(8'h12, 8'h34, "post_abort");

    // start held high: three back-to-back ops, done every W+2 cycles.
    a8 = W'($urandom); b8 = W'($urandom); start8 = 1'b1;
    exp_q.push_back(model8(a8, b8));
    n_ops = 0;
    prev_t = -1;
    for (int t = 0; t < 4 * (W + 2); t++) begin
      @(negedge clk);
      if (done8) begin
        if (n_ops > 0) check($sformatf("b2b spacing%0d", n_ops), t - prev_t, W + 2);
        prev_t = t;
        e = exp_q.pop_front();
        check($sformatf("b2b result%0d", n_ops), {cout8, sum8}, e);
        last_res = e;
        n_ops++;
        if (n_ops < 3) begin
          a8 = W'($urandom); b8 = W'($urandom);
          exp_q.push_back(model8(a8, b8));
        end else begin
          start8 = 1'b0;
          break;
        end
      end
    end
    start8 = 1'b0;
    check("b2b op_count", n_ops, 3);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      op8(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), $sformatf("rnd%0d", i));
    end

    // Exhaustive sweep on the 4-bit instance.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(W4'(x), W4'(y));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, meaning a request to begin an addition, sampled on the clk rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, meaning operand A, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, meaning operand B, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, meaning an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, meaning a single-cycle pulse that marks sum and cout as newly valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits, meaning the result of the last completed addition.
REQ-010 The block SHALL have port cout, output, 1 bit, meaning the carry-out of the last completed addition.

Function
REQ-011 The block SHALL add bit-serially, one bit per cycle, LSB first, using a one-bit full-add datapath built from two halfAdder instances with an OR for carry, plus a carry flip-flop.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-013 In IDLE with start=1 at an edge, the FSM SHALL capture a and b into internal shift registers, clear the carry flip-flop and the bit counter to 0, and go to RUN.
REQ-014 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-015 In RUN, each edge SHALL apply these updates: compute s = a_sh[0]^b_sh[0]^carry; shift s into the MSB of the result shift register; shift a_sh and b_sh right by one; update carry to the majority of (a_sh[0], b_sh[0], carry); increment the counter.
REQ-016 The RUN-to-DONE transition SHALL occur on the edge that processes bit WIDTH-1, so the FSM is in RUN for exactly WIDTH cycles.
REQ-017 On entry to DONE, the block SHALL copy the result shift register to sum and the final carry to cout in that same edge.
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-019 busy SHALL equal 1 exactly when state is RUN.
REQ-020 done SHALL equal 1 exactly when state is DONE.
REQ-021 Latency: if start is accepted at edge 0, done SHALL be high during the cycle after edge WIDTH, and busy SHALL drop in the same cycle.
REQ-022 The block SHALL ignore start while in RUN or DONE; the captured operands and results SHALL be unaffected.
REQ-023 start held high continuously SHALL give back-to-back operations with one IDLE cycle between DONE and the next RUN.
REQ-024 sum and cout SHALL hold their values from the last DONE until the next DONE, including through later RUN periods.
REQ-025 Changes on a and b after capture SHALL NOT affect the result in progress.
REQ-026 The result SHALL be (a + b) mod 2^WIDTH on sum, with cout equal to bit WIDTH of the true sum.

Reset
REQ-027 When rst_n=0, the block SHALL, asynchronously and regardless of clk, set state to IDLE, busy to 0, done to 0, sum to 0, cout to 0, and clear the carry flip-flop, counter and shift registers.
REQ-028 A reset asserted during RUN SHALL abort the operation with no done pulse, and sum/cout SHALL read 0.
REQ-029 After rst_n rises, the first edge SHALL be able to accept start.

Verification
REQ-030 Bench (WIDTH=8): a=0x00, b=0x00, start for 1 cycle -> busy high for 8 cycles, done pulses 1 cycle after edge 8, sum=0x00, cout=0.
REQ-031 Bench: a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xA5, b=0x5A -> sum=0xFF, cout=0; a=0x80, b=0x80 -> sum=0x00, cout=1.
REQ-032 Bench: start accepted with a=0x03, b=0x04, then start pulsed with a=0xFF, b=0xFF during RUN -> sum=0x07, cout=0, exactly one done pulse.
REQ-033 Bench: rst_n pulsed low mid-RUN (after 4 bits) -> busy=0, done never pulses, sum=0x00, cout=0; a new start afterwards completes correctly.
REQ-034 Bench: start held high for 3 operations -> done pulses spaced WIDTH+2 cycles apart, each result matching its captured operands.
REQ-035 Bench: exhaustive 4-bit run (WIDTH=4), all 256 operand pairs -> every {cout,sum} equals a+b.
